uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter feeding one UART transmitter
// A grant is held for a whole packet and revoked only by the last byte's tx_done or by an idle timeout.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*8-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  input  logic               tx_done_i,
  output logic               timeout_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(IDLE_TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GRANT, SEND, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic          timeout_q, timeout_d;

  logic [IW-1:0] arb_idx;
  logic          arb_hit;
  logic [IW:0]   sum;
  logic          g_valid;
  logic [IW-1:0] next_ptr;

  // First requesting index at or above rr_q, wrapping modulo N_REQ.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_q;
    sum     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (!arb_hit && req_valid_i[sum[IW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = sum[IW-1:0];
      end
    end
  end

  assign g_valid  = req_valid_i[g_q];
  assign next_ptr = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      data_q    <= 8'h00;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  // The idle counter defaults to zero, so it only survives consecutive silent GRANT cycles.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    cnt_d     = '0;
    data_d    = data_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_hit) begin
          g_d     = arb_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (g_valid) begin
          data_d  = req_data_i[8*g_q +: 8];
          last_d  = req_last_i[g_q];
          state_d = SEND;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          rr_d      = next_ptr;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (tx_ready_i) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done_i) begin
          if (last_q) begin
            rr_d    = next_ptr;
            state_d = IDLE;
          end else begin
            state_d = GRANT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o     = (state_q == IDLE) ? '0 : (ONE_HOT0 << g_q);
  assign req_ready_o = (state_q == GRANT) ? grant_o : '0;
  assign tx_valid_o  = (state_q == SEND);
  assign tx_data_o   = data_q;
  assign timeout_o   = timeout_q;

endmodule
